// File: rtl/issue_pkg.sv
// Shared types for the in-order issue scheduler.
package issue_pkg;

    localparam int ISSUE_TAG_W = 4;

    typedef enum logic [1:0] {
        UNIT_BJ  = 2'd0,
        UNIT_INT = 2'd1,
        UNIT_MEM = 2'd2,
        UNIT_MD  = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SEREX = 2'd2
    } sched_state_e;

    typedef struct packed {
        unit_e                  unit;
        logic [ISSUE_TAG_W-1:0] tag;
        logic                   serial;
        logic                   div;
    } issue_entry_t;

    function automatic logic [3:0] unit_onehot(unit_e u);
        return 4'b0001 << u;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Small synchronous FIFO of decoded ops; flush empties it in one cycle.
module issue_fifo
    import issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iPush,
    input  logic         iPop,
    input  logic         iFlush,
    input  issue_entry_t iData,
    output issue_entry_t oHead,
    output logic         oFull,
    output logic         oEmpty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    issue_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_rp;
    logic [CW-1:0]  r_cnt;
    logic           w_pop;
    logic           w_push;

    assign oFull  = (r_cnt == CW'(DEPTH));
    assign oEmpty = (r_cnt == '0);
    assign oHead  = r_mem[r_rp];

    // A pop frees the slot in the same cycle, so a full FIFO can still push.
    assign w_pop  = iPop && !oEmpty;
    assign w_push = iPush && (!oFull || w_pop);

    always_ff @(posedge iClk) begin
        if (iRst || iFlush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge iClk) begin
        if (w_push && !iFlush) r_mem[r_wp] <= iData;
    end

endmodule

// File: rtl/issue_sched.sv
// In-order issue of the FIFO head to BJ/INT/MEM/MD units with
// mult/div busy countdown, serial-op drain and outstanding tracking.
module issue_sched
    import issue_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TAG_W   = ISSUE_TAG_W,
    parameter int MAX_OUT = 7,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 19
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [1:0]       iUnit,
    input  logic [TAG_W-1:0] iTag,
    input  logic             iSerial,
    input  logic             iDiv,
    input  logic [3:0]       iUnitReady,
    input  logic [3:0]       iUnitDone,
    input  logic             iFlush,
    output logic [3:0]       oIssue,
    output logic [TAG_W-1:0] oIssueTag,
    output logic             oMdBusy,
    output logic             oIdle
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = OW + 1;
    localparam int LM = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MW = $clog2(LM + 1);

    sched_state_e  r_state;
    logic [OW-1:0] r_out;
    logic [MW-1:0] r_md_cnt;

    issue_entry_t  w_in;
    issue_entry_t  w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_permit;
    logic          w_issue;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_dn;
    logic [OW-1:0] w_out_nxt;

    assign w_in = '{unit: unit_e'(iUnit), tag: iTag,
                    serial: iSerial, div: iDiv};
    assign w_push = iValid && oReady;

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (w_push),
        .iPop   (w_issue),
        .iFlush (iFlush),
        .iData  (w_in),
        .oHead  (w_head),
        .oFull  (w_full),
        .oEmpty (w_empty)
    );

    always_comb begin
        w_permit = 1'b0;
        unique case (r_state)
            RUN:     w_permit = !w_head.serial;
            DRAIN:   w_permit = (r_out == '0) && (r_md_cnt == '0);
            default: w_permit = 1'b0;
        endcase
    end

    assign w_issue = !w_empty && iUnitReady[w_head.unit]
                  && (r_out < OW'(MAX_OUT))
                  && ((w_head.unit != UNIT_MD) || (r_md_cnt == '0))
                  && w_permit && !iFlush;

    // Net adjust; excess done pulses saturate at zero.
    assign w_sum     = {1'b0, r_out} + SW'(w_issue);
    assign w_dn      = SW'($countones(iUnitDone));
    assign w_out_nxt = (w_dn > w_sum) ? '0 : OW'(w_sum - w_dn);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_out    <= '0;
            r_md_cnt <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (w_issue && (w_head.unit == UNIT_MD))
                r_md_cnt <= w_head.div ? MW'(DIV_LAT) : MW'(MUL_LAT);
            else if (r_md_cnt != '0)
                r_md_cnt <= r_md_cnt - MW'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= RUN;
        end else begin
            unique case (r_state)
                RUN:
                    if (!iFlush && !w_empty && w_head.serial)
                        r_state <= DRAIN;
                DRAIN:
                    if (iFlush)       r_state <= RUN;
                    else if (w_issue) r_state <= SEREX;
                SEREX:
                    if ((iUnitDone != '0) && (w_out_nxt == '0))
                        r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) assert (w_dn <= w_sum);
    end

    assign oReady    = !w_full;
    assign oIssue    = w_issue ? unit_onehot(w_head.unit) : '0;
    assign oIssueTag = w_issue ? w_head.tag : '0;
    assign oMdBusy   = (r_md_cnt != '0);
    assign oIdle     = w_empty && (r_out == '0) && (r_state == RUN);

endmodule

// File: tb/tb_issue_sched.sv
// Directed vector bench for issue_sched.
module tb_issue_sched;

    logic       iClk;
    logic       iRst;
    logic       iValid;
    logic       oReady;
    logic [1:0] iUnit;
    logic [3:0] iTag;
    logic       iSerial;
    logic       iDiv;
    logic [3:0] iUnitReady;
    logic [3:0] iUnitDone;
    logic       iFlush;
    logic [3:0] oIssue;
    logic [3:0] oIssueTag;
    logic       oMdBusy;
    logic       oIdle;

    int total = 0;
    int bad   = 0;

    issue_sched dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iValid     (iValid),
        .oReady     (oReady),
        .iUnit      (iUnit),
        .iTag       (iTag),
        .iSerial    (iSerial),
        .iDiv       (iDiv),
        .iUnitReady (iUnitReady),
        .iUnitDone  (iUnitDone),
        .iFlush     (iFlush),
        .oIssue     (oIssue),
        .oIssueTag  (oIssueTag),
        .oMdBusy    (oMdBusy),
        .oIdle      (oIdle)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic       v;
        logic [1:0] u;
        logic [3:0] t;
        logic       s;
        logic       d;
        logic [3:0] rdy;
        logic [3:0] dn;
        logic       fl;
        logic [3:0] e_iss;
        logic [3:0] e_tag;
        logic       e_rdy;
        logic       e_busy;
        logic       e_idle;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic v, logic [1:0] u, logic [3:0] t, logic s,
        logic [3:0] dn, logic fl, logic [3:0] ei,
        logic [3:0] et, logic er, logic eb, logic el);
        vec_t r;
        r.v = v; r.u = u; r.t = t; r.s = s; r.d = 1'b0;
        r.rdy = 4'hF; r.dn = dn; r.fl = fl;
        r.e_iss = ei; r.e_tag = et; r.e_rdy = er;
        r.e_busy = eb; r.e_idle = el;
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic drive(logic v, logic [1:0] u, logic [3:0] t,
                         logic s, logic d, logic [3:0] rdy,
                         logic [3:0] dn, logic fl);
        iValid = v; iUnit = u; iTag = t; iSerial = s; iDiv = d;
        iUnitReady = rdy; iUnitDone = dn; iFlush = fl;
    endtask

    task automatic do_reset(string n);
        @(negedge iClk);
        iRst = 1'b1;
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
        @(posedge iClk);
        @(negedge iClk);
        #1;
        chk({n, ".ready"}, oReady, 1);
        chk({n, ".issue"}, oIssue, 0);
        chk({n, ".tag"}, oIssueTag, 0);
        chk({n, ".busy"}, oMdBusy, 0);
        chk({n, ".idle"}, oIdle, 1);
        iRst = 1'b0;
    endtask

    initial begin
        iRst = 1'b1;
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0, 0);

        // basic INT issue and idle return
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        // serial BJ behind INT and MEM
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 2, 2, 0, 0, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5, 1, 0, 0, 4, 2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 6, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0));
        // flush in DRAIN while multiply countdown runs
        tbl.push_back(mk(1, 3, 7, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 8, 1, 0, 0, 8, 7, 1, 0, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0, 1, 0, 0));
        // outstanding limit
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(1, 1, 4'(k), 0, 0, 0, 2, 4'(k - 1), 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 8, 0, 0, 0, 2, 7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 2, 8, 1, 0, 0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 9, 1, 0, 0));
        tbl.push_back(mk(1, 1, 10, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        do_reset("rst0");

        foreach (tbl[i]) begin
            @(negedge iClk);
            drive(tbl[i].v, tbl[i].u, tbl[i].t, tbl[i].s, tbl[i].d,
                  tbl[i].rdy, tbl[i].dn, tbl[i].fl);
            #1;
            chk($sformatf("row%0d.issue", i), oIssue, tbl[i].e_iss);
            chk($sformatf("row%0d.tag", i), oIssueTag, tbl[i].e_tag);
            chk($sformatf("row%0d.ready", i), oReady, tbl[i].e_rdy);
            chk($sformatf("row%0d.busy", i), oMdBusy, tbl[i].e_busy);
            chk($sformatf("row%0d.idle", i), oIdle, tbl[i].e_idle);
        end

        // reset with 7 ops outstanding and one queued
        do_reset("rst_mid");

        // divide then multiply
        @(negedge iClk);
        drive(1, 3, 1, 0, 1, 4'hF, 0, 0);
        #1 chk("md.first_idle", oIssue, 0);
        @(negedge iClk);
        drive(1, 3, 2, 0, 0, 4'hF, 0, 0);
        #1;
        chk("md.div_issue", oIssue, 4'b1000);
        chk("md.div_tag", oIssueTag, 1);
        chk("md.div_busy0", oMdBusy, 0);
        for (int i = 0; i < 19; i++) begin
            @(negedge iClk);
            drive(0, 0, 0, 0, 0, 4'hF, 0, 0);
            #1;
            chk($sformatf("md.div_busy%0d", i), oMdBusy, 1);
            chk($sformatf("md.div_hold%0d", i), oIssue, 0);
        end
        @(negedge iClk);
        #1;
        chk("md.mul_issue", oIssue, 4'b1000);
        chk("md.mul_tag", oIssueTag, 2);
        chk("md.mul_busy0", oMdBusy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            #1 chk($sformatf("md.mul_busy%0d", i), oMdBusy, 1);
        end
        @(negedge iClk);
        #1 chk("md.mul_free", oMdBusy, 0);

        do_reset("rst2");

        // full FIFO, then pop and push together
        @(negedge iClk);
        drive(1, 1, 1, 0, 0, 4'h0, 0, 0);
        #1 chk("full.r0", oReady, 1);
        @(negedge iClk);
        drive(1, 1, 2, 0, 0, 4'h0, 0, 0);
        #1 chk("full.r1", oReady, 1);
        @(negedge iClk);
        drive(1, 1, 3, 0, 0, 4'h0, 0, 0);
        #1;
        chk("full.r2", oReady, 0);
        chk("full.noiss", oIssue, 0);
        @(negedge iClk);
        drive(1, 1, 3, 0, 0, 4'b0010, 0, 0);
        #1;
        chk("full.iss1", oIssue, 4'b0010);
        chk("full.tag1", oIssueTag, 1);
        chk("full.r3", oReady, 0);
        @(negedge iClk);
        drive(1, 1, 3, 0, 0, 4'b0010, 0, 0);
        #1;
        chk("full.tag2", oIssueTag, 2);
        chk("full.r4", oReady, 1);
        @(negedge iClk);
        drive(0, 0, 0, 0, 0, 4'b0010, 0, 0);
        #1;
        chk("full.tag3", oIssueTag, 3);
        chk("full.iss3", oIssue, 4'b0010);
        @(negedge iClk);
        #1;
        chk("full.empty_iss", oIssue, 0);
        chk("full.r5", oReady, 1);

        do_reset("rst3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
